// File: rtl/img_sram_pkg.sv
// Shared types for the image SRAM wrapper and its sequencer/arbiter.
// The SRAM control bundle is registered by the controller and sampled by img_sram on clk low.
package img_sram_pkg;

    typedef struct packed {
        logic       write_en;
        logic       sense_en;
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] din;
    } st_img_sram_ctrl;

    // write = we1/se1, read = we0/se0, hold = we0/se1
    localparam st_img_sram_ctrl IMG_SRAM_HOLD =
        '{write_en: 1'b0, sense_en: 1'b1, row: 8'h00, col: 8'h00, din: 8'h00};

    typedef enum logic [1:0] {IDLE, SGL, BURST, GAP} e_img_sram_ctrl_state;

    typedef enum logic {REQ_A, REQ_B} e_img_sram_req;

    function automatic st_img_sram_ctrl img_sram_op(input logic       we,
                                                    input logic [7:0] row,
                                                    input logic [7:0] col,
                                                    input logic [7:0] din);
        return '{write_en: we, sense_en: we, row: row, col: col, din: din};
    endfunction

endpackage

// File: rtl/img_sram_rr_arb.sv
// Two-way round-robin grant. Grant is combinational on the requests; the pointer
// moves to the other requester whenever a grant is actually taken.
module img_sram_rr_arb
    import img_sram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          take,
    output e_img_sram_req gnt
);

    e_img_sram_req ptr;

    always_comb begin
        gnt = ptr;
        if (req_a && !req_b)
            gnt = REQ_A;
        else if (req_b && !req_a)
            gnt = REQ_B;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= REQ_A;
        else if (take)
            ptr <= (gnt == REQ_A) ? REQ_B : REQ_A;
    end

endmodule

// File: rtl/img_sram_ctrl.sv
// Sequencer/arbiter sharing the single img_sram port between the host loader
// (port A, single beats) and the convolution engine (port B, row-major read bursts).
module img_sram_ctrl
    import img_sram_pkg::*;
#(
    parameter int WR_RD_GAP = 1,
    parameter int LEN_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_we,
    input  logic [7:0]       a_row,
    input  logic [7:0]       a_col,
    input  logic [7:0]       a_wdata,
    output logic             a_rvalid,
    output logic [7:0]       a_rdata,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [7:0]       b_row,
    input  logic [7:0]       b_col,
    input  logic [LEN_W-1:0] b_len,
    output logic             b_rvalid,
    output logic [7:0]       b_rdata,
    output logic             b_done,
    output st_img_sram_ctrl  sram_ctrl,
    input  logic [7:0]       sram_dout
);

    localparam logic [1:0]       GAP_INIT = 2'(WR_RD_GAP);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO      = LEN_W'(2);

    e_img_sram_ctrl_state state, state_nx;
    e_img_sram_req        gnt;
    logic [LEN_W-1:0]     beat_cnt;
    logic [1:0]           gap_cnt;
    logic [15:0]          baddr, baddr_nx;
    logic                 free, rd_block, b_empty, gnt_rd, take;
    logic                 rd_a, rd_b, rd_last;

    img_sram_rr_arb u_arb (
        .clk  (clk),
        .rst  (rst),
        .req_a(a_valid),
        .req_b(b_valid),
        .take (take),
        .gnt  (gnt)
    );

    always_comb begin
        free     = 1'b0;
        b_empty  = (b_len == '0);
        rd_block = (gap_cnt != 2'd0);
        baddr_nx = baddr + 16'd1;   // {row,col} increment gives row-major order and 255/255 wrap
        case (state)
            IDLE, SGL: free = 1'b1;
            BURST:     free = (beat_cnt == ONE);
            default:   free = (gap_cnt == 2'd0);
        endcase
        // an empty burst touches no SRAM, so the write-to-read gap does not apply to it
        gnt_rd  = (gnt == REQ_A) ? !a_we : !b_empty;
        take    = !rst && free && (a_valid || b_valid) && !(gnt_rd && rd_block);
        a_ready = take && (gnt == REQ_A);
        b_ready = take && (gnt == REQ_B);

        state_nx = state;
        if (free) begin
            if (a_ready)
                state_nx = SGL;
            else if (b_ready)
                state_nx = b_empty ? IDLE : BURST;
            else if (a_valid || b_valid)
                state_nx = GAP;
            else
                state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sram_ctrl <= IMG_SRAM_HOLD;
            beat_cnt  <= '0;
            gap_cnt   <= 2'd0;
            baddr     <= 16'd0;
            rd_a      <= 1'b0;
            rd_b      <= 1'b0;
            rd_last   <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            b_done    <= 1'b0;
            a_rdata   <= 8'h00;
            b_rdata   <= 8'h00;
        end else begin
            state     <= state_nx;
            sram_ctrl <= IMG_SRAM_HOLD;
            rd_a      <= 1'b0;
            rd_b      <= 1'b0;
            rd_last   <= 1'b0;

            if (a_ready && a_we)
                gap_cnt <= GAP_INIT;
            else if (rd_block)
                gap_cnt <= gap_cnt - 2'd1;

            if (a_ready) begin
                sram_ctrl <= img_sram_op(a_we, a_row, a_col, a_we ? a_wdata : 8'h00);
                rd_a      <= !a_we;
            end else if (b_ready && !b_empty) begin
                sram_ctrl <= img_sram_op(1'b0, b_row, b_col, 8'h00);
                baddr     <= {b_row, b_col};
                beat_cnt  <= b_len;
                rd_b      <= 1'b1;
                rd_last   <= (b_len == ONE);
            end else if (state == BURST && beat_cnt != ONE) begin
                sram_ctrl <= img_sram_op(1'b0, baddr_nx[15:8], baddr_nx[7:0], 8'h00);
                baddr     <= baddr_nx;
                beat_cnt  <= beat_cnt - ONE;
                rd_b      <= 1'b1;
                rd_last   <= (beat_cnt == TWO);
            end

            // dout is only driven while clk is low after the read issue, so capture it on the next edge
            a_rvalid <= rd_a;
            b_rvalid <= rd_b;
            b_done   <= rd_last || (b_ready && b_empty);
            if (rd_a)
                a_rdata <= sram_dout;
            if (rd_b)
                b_rdata <= sram_dout;
        end
    end

endmodule
